// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial test-pattern source for sequence detectors.
// Emits a captured WIDTH-bit pattern MSB first, reps times, with gap zero bits
// between occurrences. mark flags the last bit of each occurrence.
// All outputs are registered and reflect the bit being driven this cycle.
//
// Optional feature: define SEQ_GEN_OVERLAP_EN so that, when the captured gap is
// 0, each following occurrence reuses the last OVL bits of the previous one.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - begin a transmission (sampled only in IDLE)
//   pattern - WIDTH-bit pattern, MSB sent first
//   reps    - number of occurrences
//   gap     - zero bits between occurrences
//   x       - serial data bit (0 whenever valid is 0)
//   valid   - x carries a pattern or gap bit
//   mark    - last bit of an occurrence
//   busy    - transmission in progress
//   done    - one-cycle completion pulse
module seq_pattern_gen #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned OVL   = 2,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             valid,
  output logic             mark,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);
`ifdef SEQ_GEN_OVERLAP_EN
  localparam logic [IDX_W-1:0] OVL_IDX = IDX_W'(WIDTH - 1 - OVL);
`endif

  // Reject an overlap that would swallow the whole pattern.
  if (OVL >= WIDTH) begin : g_bad_ovl
    $error("seq_pattern_gen: OVL must be smaller than WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_pat;
  logic [CNT_W-1:0]   r_left;    // occurrences still to start after the current one
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gcnt;    // gap cycles remaining after the current one
  logic [IDX_W-1:0]   r_idx;

  state_t             w_state_n;
  logic [WIDTH-1:0]   w_pat_n;
  logic [CNT_W-1:0]   w_left_n;
  logic [GAP_W-1:0]   w_gap_n;
  logic [GAP_W-1:0]   w_gcnt_n;
  logic [IDX_W-1:0]   w_idx_n;
  logic               w_x_n;
  logic               w_valid_n;
  logic               w_mark_n;
  logic               w_busy_n;
  logic               w_done_n;

  // State, captured configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_left  <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_idx   <= '0;
      x       <= 1'b0;
      valid   <= 1'b0;
      mark    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pat   <= w_pat_n;
      r_left  <= w_left_n;
      r_gap   <= w_gap_n;
      r_gcnt  <= w_gcnt_n;
      r_idx   <= w_idx_n;
      x       <= w_x_n;
      valid   <= w_valid_n;
      mark    <= w_mark_n;
      busy    <= w_busy_n;
      done    <= w_done_n;
    end
  end

  // Next-state logic; outputs are derived from the next state so the
  // registered outputs describe the bit on the wire in the following cycle.
  always_comb begin
    w_state_n = r_state;
    w_pat_n   = r_pat;
    w_left_n  = r_left;
    w_gap_n   = r_gap;
    w_gcnt_n  = r_gcnt;
    w_idx_n   = r_idx;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_pat_n = pattern;
          w_gap_n = gap;
          w_idx_n = TOP_IDX;
          if (reps == '0) begin
            w_state_n = DONE;
            w_left_n  = '0;
          end else begin
            w_state_n = SHIFT;
            w_left_n  = reps - 1'b1;
          end
        end
      end
      SHIFT: begin
        if (r_idx != '0) begin
          w_idx_n = r_idx - 1'b1;
        end else if (r_left == '0) begin
          w_state_n = DONE;
        end else begin
          w_left_n = r_left - 1'b1;
          if (r_gap != '0) begin
            w_state_n = GAP;
            w_gcnt_n  = r_gap - 1'b1;
          end else begin
`ifdef SEQ_GEN_OVERLAP_EN
            w_idx_n = OVL_IDX;
`else
            w_idx_n = TOP_IDX;
`endif
          end
        end
      end
      GAP: begin
        if (r_gcnt == '0) begin
          w_state_n = SHIFT;
          w_idx_n   = TOP_IDX;
        end else begin
          w_gcnt_n = r_gcnt - 1'b1;
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    w_valid_n = (w_state_n == SHIFT) || (w_state_n == GAP);
    w_busy_n  = w_valid_n;
    w_done_n  = (w_state_n == DONE);
    w_x_n     = (w_state_n == SHIFT) ? w_pat_n[w_idx_n] : 1'b0;
    w_mark_n  = (w_state_n == SHIFT) && (w_idx_n == '0);
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen (default parameters). Outputs are compared
// as the packed vector {x, valid, mark, busy, done} one time unit after each edge.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] pattern;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       x, valid, mark, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic [4:0] pat;
    logic [3:0] reps;
    logic [3:0] gap;
    logic [4:0] exp;   // {x, valid, mark, busy, done}
  } vec_t;

  vec_t tbl[$];

  seq_pattern_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .gap     (gap),
    .x       (x),
    .valid   (valid),
    .mark    (mark),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic s, input logic [4:0] p,
                              input logic [3:0] n, input logic [3:0] g,
                              input logic [4:0] e);
    vec_t v;
    v.rst = r; v.st = s; v.pat = p; v.reps = n; v.gap = g; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic s, input logic [4:0] p,
                      input logic [3:0] n, input logic [3:0] g);
    rst = r; start = s; pattern = p; reps = n; gap = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [4:0] e);
    logic [4:0] got;
    got = {x, valid, mark, busy, done};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got xvmbd=%b want %b", nm, idx, got, e);
    end
  endtask

  // One transmission: start pulse (or held start), n valid bits, done, idle.
  task automatic tx(input string nm, input logic [4:0] p, input logic [3:0] n,
                    input logic [3:0] g, input logic hold,
                    input logic [31:0] bits, input logic [31:0] marks, input int len);
    for (int i = 0; i < len; i++) begin
      step(1'b0, (i == 0) ? 1'b1 : hold, p, n, g);
      chk(nm, i, {bits[len-1-i], 1'b1, marks[len-1-i], 1'b1, 1'b0});
    end
    step(1'b0, hold, p, n, g);
    chk(nm, len, 5'b00001);
    step(1'b0, hold, p, n, g);
    chk(nm, len + 1, 5'b00000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0; gap = '0;

    // Reset, reset-over-start, single 10010, reps=0, start ignored while busy.
    add(1, 0, 5'b10010, 4'd1, 4'd0, 5'b00000);
    add(1, 1, 5'b10010, 4'd1, 4'd0, 5'b00000);
    add(0, 1, 5'b10010, 4'd1, 4'd0, 5'b11010);
    add(0, 0, 5'b10010, 4'd1, 4'd0, 5'b01010);
    add(0, 0, 5'b10010, 4'd1, 4'd0, 5'b01010);
    add(0, 0, 5'b10010, 4'd1, 4'd0, 5'b11010);
    add(0, 0, 5'b10010, 4'd1, 4'd0, 5'b01110);
    add(0, 0, 5'b10010, 4'd1, 4'd0, 5'b00001);
    add(0, 0, 5'b10010, 4'd1, 4'd0, 5'b00000);
    add(0, 1, 5'b10010, 4'd0, 4'd0, 5'b00001);
    add(0, 0, 5'b10010, 4'd0, 4'd0, 5'b00000);
    add(0, 1, 5'b01101, 4'd1, 4'd0, 5'b01010);
    add(0, 1, 5'b11111, 4'd3, 4'd2, 5'b11010);
    add(0, 1, 5'b11111, 4'd3, 4'd2, 5'b11010);
    add(0, 1, 5'b11111, 4'd3, 4'd2, 5'b01010);
    add(0, 1, 5'b11111, 4'd3, 4'd2, 5'b11110);
    add(0, 1, 5'b11111, 4'd3, 4'd2, 5'b00001);
    add(0, 0, 5'b11111, 4'd3, 4'd2, 5'b00000);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].pat, tbl[i].reps, tbl[i].gap);
      chk("table", i, tbl[i].exp);
    end

    // 10010 00 10010 00 10010
    tx("reps3_gap2", 5'b10010, 4'd3, 4'd2, 1'b0,
       32'b1001000100100010010, 32'b0000100000010000001, 19);

    // Reset while bit 3 is on the wire, then a fresh start from the MSB.
    step(1'b0, 1'b1, 5'b10010, 4'd1, 4'd0); chk("mid_rst", 0, 5'b11010);
    step(1'b0, 1'b0, 5'b10010, 4'd1, 4'd0); chk("mid_rst", 1, 5'b01010);
    step(1'b1, 1'b0, 5'b10010, 4'd1, 4'd0); chk("mid_rst", 2, 5'b00000);
    step(1'b0, 1'b0, 5'b10010, 4'd1, 4'd0); chk("mid_rst", 3, 5'b00000);
    tx("after_rst", 5'b10010, 4'd1, 4'd0, 1'b0, 32'b10010, 32'b00001, 5);

    // Start held high: two occurrences, done, IDLE, then a new transmission.
    tx("hold", 5'b10010, 4'd2, 4'd0, 1'b1, 32'b1001010010, 32'b0000100001, 10);
    step(1'b0, 1'b1, 5'b10010, 4'd2, 4'd0); chk("hold_restart", 0, 5'b11010);
    step(1'b1, 1'b0, 5'b10010, 4'd2, 4'd0); chk("hold_restart", 1, 5'b00000);
    step(1'b0, 1'b0, 5'b10010, 4'd2, 4'd0); chk("hold_restart", 2, 5'b00000);

`ifdef SEQ_GEN_OVERLAP_EN
    // 10010 010 010
    tx("overlap", 5'b10010, 4'd3, 4'd0, 1'b0,
       32'b10010010010, 32'b00001001001, 11);
`else
    // 10010 10010 10010
    tx("no_overlap", 5'b10010, 4'd3, 4'd0, 1'b0,
       32'b100101001010010, 32'b000010000100001, 15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
